// File: rtl/pht_port_arbiter.sv
// pht_port_arbiter: shares a single-port PHT between 0-cycle fetch lookups and FIFO-buffered retire updates.
// Backpressure: upd_ready drops when the FIFO is full or a drain is in progress; fetch_ready drops on update grants.
// Optional PHT_ARB_STATS_EN adds wrapping lookup/update/stall counters.
module pht_port_arbiter #(
    parameter int PC_W         = 32,
    parameter int QDEPTH       = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         fetch_valid,
    input  logic [PC_W-1:0]              fetch_pc,
    output logic                         fetch_ready,
    output logic                         fetch_pred,
    input  logic                         upd_valid,
    input  logic [PC_W-1:0]              upd_pc,
    input  logic                         upd_taken,
    output logic                         upd_ready,
    input  logic                         drain_req,
    output logic                         drain_done,
    output logic [$clog2(QDEPTH+1)-1:0]  q_count,
`ifdef PHT_ARB_STATS_EN
    output logic [31:0]                  stat_lookups,
    output logic [31:0]                  stat_updates,
    output logic [31:0]                  stat_stalls,
`endif
    output logic                         pht_enable,
    output logic [PC_W-1:0]              pht_pc,
    output logic                         pht_branch_taken,
    input  logic                         pht_prediction
);

    localparam int CW = $clog2(QDEPTH + 1);
    localparam int PW = $clog2(QDEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
    } upd_ent_t;

    state_t          state_q, state_d;
    upd_ent_t        mem_q [QDEPTH];
    upd_ent_t        mem_d [QDEPTH];
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            q_full, q_empty, enq, grant_upd, drain_exit;
    upd_ent_t        head_ent;

    assign q_full    = (count_q == CW'(QDEPTH));
    assign q_empty   = (count_q == '0);
    assign upd_ready = !q_full && (state_q != DRAIN);
    assign enq       = upd_valid && upd_ready;
    assign grant_upd = !q_empty && ((state_q == DRAIN) || !fetch_valid || q_full ||
                                    (starve_q == SW'(STARVE_LIMIT)));
    assign head_ent  = mem_q[head_q];

    assign fetch_ready      = !grant_upd;
    assign fetch_pred       = fetch_ready && pht_prediction;
    assign pht_enable       = grant_upd;
    assign pht_pc           = grant_upd ? head_ent.pc : fetch_pc;
    assign pht_branch_taken = grant_upd && head_ent.taken;
    assign q_count          = count_q;

    // Enqueue is blocked while draining, so the last grant really empties the FIFO.
    assign drain_exit = (state_q == DRAIN) &&
                        (q_empty || ((count_q == CW'(1)) && grant_upd && !enq));
    assign drain_done = drain_exit;

    always_comb begin
        mem_d    = mem_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        starve_d = starve_q;
        state_d  = state_q;

        if (enq) begin
            mem_d[tail_q] = '{pc: upd_pc, taken: upd_taken};
            tail_d        = tail_q + PW'(1);
        end
        if (grant_upd) begin
            head_d = head_q + PW'(1);
        end
        case ({enq, grant_upd})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (grant_upd || q_empty) begin
            starve_d = '0;
        end else if (fetch_valid && (starve_q != SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + SW'(1);
        end

        case (state_q)
            IDLE:    if (drain_req) state_d = DRAIN;
            DRAIN:   if (drain_exit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            starve_q <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            starve_q <= starve_d;
            mem_q    <= mem_d;
        end
    end

`ifdef PHT_ARB_STATS_EN
    logic [31:0] lookups_q, lookups_d, updates_q, updates_d, stalls_q, stalls_d;

    always_comb begin
        lookups_d = lookups_q;
        updates_d = updates_q;
        stalls_d  = stalls_q;
        if (fetch_valid && fetch_ready)  lookups_d = lookups_q + 32'd1;
        if (grant_upd)                   updates_d = updates_q + 32'd1;
        if (fetch_valid && !fetch_ready) stalls_d  = stalls_q + 32'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lookups_q <= '0;
            updates_q <= '0;
            stalls_q  <= '0;
        end else begin
            lookups_q <= lookups_d;
            updates_q <= updates_d;
            stalls_q  <= stalls_d;
        end
    end

    assign stat_lookups = lookups_q;
    assign stat_updates = updates_q;
    assign stat_stalls  = stalls_q;
`endif

endmodule

// File: tb/tb_pht_port_arbiter.sv
// Bench for pht_port_arbiter: directed vector table, hand-written corner sequences, and
// randomized traffic against a queue-based reference model with a 2-bit-counter PHT alongside.
`timescale 1ns/1ps
module tb_pht_port_arbiter;
    localparam int PC_W         = 32;
    localparam int QDEPTH       = 4;
    localparam int STARVE_LIMIT = 8;
    localparam int CW           = $clog2(QDEPTH + 1);

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            fetch_valid = 1'b0;
    logic [PC_W-1:0] fetch_pc = '0;
    logic            fetch_ready;
    logic            fetch_pred;
    logic            upd_valid = 1'b0;
    logic [PC_W-1:0] upd_pc = '0;
    logic            upd_taken = 1'b0;
    logic            upd_ready;
    logic            drain_req = 1'b0;
    logic            drain_done;
    logic [CW-1:0]   q_count;
    logic            pht_enable;
    logic [PC_W-1:0] pht_pc;
    logic            pht_branch_taken;
    logic            pht_prediction;

    always #5 clock = ~clock;

    pht_port_arbiter #(.PC_W(PC_W), .QDEPTH(QDEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clock(clock), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready), .fetch_pred(fetch_pred),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_ready(upd_ready),
        .drain_req(drain_req), .drain_done(drain_done), .q_count(q_count),
        .pht_enable(pht_enable), .pht_pc(pht_pc), .pht_branch_taken(pht_branch_taken),
        .pht_prediction(pht_prediction)
    );

    // Single-port PHT: 16 two-bit saturating counters indexed by pc[5:2].
    logic [1:0] pht_tbl [16];
    assign pht_prediction = pht_tbl[pht_pc[5:2]][1];

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) pht_tbl[i] <= 2'b00;
        end else if (pht_enable) begin
            if (pht_branch_taken) begin
                if (pht_tbl[pht_pc[5:2]] != 2'b11) pht_tbl[pht_pc[5:2]] <= pht_tbl[pht_pc[5:2]] + 2'b01;
            end else begin
                if (pht_tbl[pht_pc[5:2]] != 2'b00) pht_tbl[pht_pc[5:2]] <= pht_tbl[pht_pc[5:2]] - 2'b01;
            end
        end
    end

    typedef struct {
        logic [PC_W-1:0] pc;
        bit              t;
    } ent_t;

    ent_t mq[$];
    int   mstarve = 0;
    bit   mdrain  = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    bit o_frdy, o_en, o_urdy, o_done;
    int o_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit fv, input logic [31:0] fpc, input bit uv,
                       input logic [31:0] upc, input bit ut, input bit dr);
        int cnt;
        bit gu, urdy, enq, done, pred, ebt;
        logic [31:0] epc;
        @(negedge clock);
        fetch_valid = fv;
        fetch_pc    = fpc;
        upd_valid   = uv;
        upd_pc      = upc;
        upd_taken   = ut;
        drain_req   = dr;
        #1;
        cnt  = mq.size();
        urdy = (cnt != QDEPTH) && !mdrain;
        gu   = (cnt != 0) && (mdrain || !fv || cnt == QDEPTH || mstarve == STARVE_LIMIT);
        enq  = uv && urdy;
        done = mdrain && (cnt == 0 || (cnt == 1 && gu && !enq));
        if (gu) begin
            epc = mq[0].pc;
            ebt = mq[0].t;
        end else begin
            epc = fpc;
            ebt = 1'b0;
        end
        pred = gu ? 1'b0 : pht_tbl[fpc[5:2]][1];
        chk("q_count",          32'(q_count),          32'(cnt));
        chk("upd_ready",        32'(upd_ready),        32'(urdy));
        chk("fetch_ready",      32'(fetch_ready),      32'(!gu));
        chk("pht_enable",       32'(pht_enable),       32'(gu));
        chk("pht_pc",           pht_pc,                epc);
        chk("pht_branch_taken", 32'(pht_branch_taken), 32'(ebt));
        chk("fetch_pred",       32'(fetch_pred),       32'(pred));
        chk("drain_done",       32'(drain_done),       32'(done));
        o_frdy = fetch_ready;
        o_en   = pht_enable;
        o_urdy = upd_ready;
        o_done = drain_done;
        o_q    = int'(q_count);
        @(posedge clock);
        if (gu) void'(mq.pop_front());
        if (enq) mq.push_back('{pc: upc, t: ut});
        if (gu || cnt == 0) mstarve = 0;
        else if (fv && mstarve < STARVE_LIMIT) mstarve++;
        if (mdrain) begin
            if (done) mdrain = 1'b0;
        end else if (dr) begin
            mdrain = 1'b1;
        end
    endtask

    typedef struct {
        bit              fv;
        bit              uv;
        logic [PC_W-1:0] upc;
        bit              ut;
        bit              dr;
        int              q;
        bit              urdy;
        bit              en;
        bit              frdy;
        bit              done;
    } vec_t;

    initial begin
        vec_t vt [11];
        int   nf, ndone;
        bit   got;

        vt[0]  = '{0, 0, 32'h0, 0, 0,  0, 1, 0, 1, 0};
        vt[1]  = '{0, 1, 32'h0, 1, 0,  0, 1, 0, 1, 0};
        vt[2]  = '{0, 0, 32'h0, 0, 0,  1, 1, 1, 0, 0};
        vt[3]  = '{0, 0, 32'h0, 0, 0,  0, 1, 0, 1, 0};
        vt[4]  = '{0, 1, 32'h0, 1, 0,  0, 1, 0, 1, 0};
        vt[5]  = '{0, 1, 32'h0, 1, 0,  1, 1, 1, 0, 0};
        vt[6]  = '{0, 0, 32'h0, 0, 0,  1, 1, 1, 0, 0};
        vt[7]  = '{0, 0, 32'h0, 0, 0,  0, 1, 0, 1, 0};
        vt[8]  = '{0, 0, 32'h0, 0, 1,  0, 1, 0, 1, 0};
        vt[9]  = '{0, 0, 32'h0, 0, 0,  0, 0, 0, 1, 1};
        vt[10] = '{0, 0, 32'h0, 0, 0,  0, 1, 0, 1, 0};

        // Reset state
        #12;
        chk("rst_q_count",    32'(q_count),    32'd0);
        chk("rst_upd_ready",  32'(upd_ready),  32'd1);
        chk("rst_pht_enable", 32'(pht_enable), 32'd0);
        chk("rst_drain_done", 32'(drain_done), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Fetch-idle updates to PC 0, then a drain request with an empty FIFO
        for (int i = 0; i < 11; i++) begin
            cyc(vt[i].fv, 32'h40, vt[i].uv, vt[i].upc, vt[i].ut, vt[i].dr);
            chk($sformatf("vec%0d_q", i),    32'(o_q),    32'(vt[i].q));
            chk($sformatf("vec%0d_urdy", i), 32'(o_urdy), 32'(vt[i].urdy));
            chk($sformatf("vec%0d_en", i),   32'(o_en),   32'(vt[i].en));
            chk($sformatf("vec%0d_frdy", i), 32'(o_frdy), 32'(vt[i].frdy));
            chk($sformatf("vec%0d_done", i), 32'(o_done), 32'(vt[i].done));
        end
        #1;
        chk("pht_row0_saturated", 32'(pht_tbl[0]), 32'd3);

        // Starvation: one queued update against continuous fetch
        cyc(1, 32'h44, 1, 32'h104, 1, 0);
        nf  = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            cyc(1, 32'h48, 0, 32'h0, 0, 0);
            if (o_en) got = 1'b1;
            else if (o_frdy) nf++;
        end
        chk("starve_forced_update", 32'(got), 32'd1);
        chk("starve_fetch_grants",  32'(nf),  32'd8);
        cyc(1, 32'h48, 0, 32'h0, 0, 0);
        chk("starve_fetch_resumes", 32'(o_frdy), 32'd1);
        chk("starve_no_update",     32'(o_en),   32'd0);

        // Full FIFO under continuous fetch
        for (int i = 0; i < 4; i++) cyc(1, 32'h50, 1, 32'h200 + 32'(i * 4), i[0], 0);
        cyc(1, 32'h50, 1, 32'hDEAD0, 1, 0);
        chk("full_q_count",    32'(o_q),    32'd4);
        chk("full_upd_ready",  32'(o_urdy), 32'd0);
        chk("full_forced_upd", 32'(o_en),   32'd1);
        cyc(1, 32'h50, 0, 32'h0, 0, 0);
        chk("after_full_q",    32'(o_q),    32'd3);
        chk("after_full_urdy", 32'(o_urdy), 32'd1);

        // Drain of 3 queued entries with fetch active and updates offered
        cyc(1, 32'h54, 0, 32'h0, 0, 1);
        chk("drain_req_cycle_en", 32'(o_en), 32'd0);
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 32'h54, 1, 32'h300, 1, 1);
            chk($sformatf("drain%0d_en", i),   32'(o_en),   32'd1);
            chk($sformatf("drain%0d_urdy", i), 32'(o_urdy), 32'd0);
            if (o_done) ndone++;
        end
        cyc(1, 32'h54, 0, 32'h0, 0, 0);
        if (o_done) ndone++;
        chk("drain_done_once", 32'(ndone),  32'd1);
        chk("drain_idle_urdy", 32'(o_urdy), 32'd1);
        chk("drain_empty_q",   32'(o_q),    32'd0);

        // Reset asserted mid-drain with 2 entries
        cyc(1, 32'h58, 1, 32'h400, 1, 0);
        cyc(1, 32'h58, 1, 32'h404, 0, 0);
        cyc(1, 32'h58, 0, 32'h0, 0, 1);
        @(negedge clock);
        reset       = 1'b0;
        fetch_valid = 1'b0;
        upd_valid   = 1'b0;
        drain_req   = 1'b0;
        #1;
        chk("mid_rst_q_count",    32'(q_count),    32'd0);
        chk("mid_rst_pht_enable", 32'(pht_enable), 32'd0);
        chk("mid_rst_drain_done", 32'(drain_done), 32'd0);
        chk("mid_rst_upd_ready",  32'(upd_ready),  32'd1);
        mq.delete();
        mstarve = 0;
        mdrain  = 1'b0;
        @(negedge clock);
        chk("mid_rst_no_pulse", 32'(drain_done), 32'd0);
        reset = 1'b1;
        cyc(0, 32'h60, 0, 32'h0, 0, 0);
        chk("post_rst_done", 32'(o_done), 32'd0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) != 0, 32'($urandom_range(0, 255)),
                $urandom_range(0, 1) == 1, 32'($urandom_range(0, 255)),
                $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pht_port_arbiter.md
Name: pht_port_arbiter

Overview:
- Shares the single-port two-bit-counter pattern history table between two requesters: the fetch-stage lookup port and the retire-stage update port.
- Buffers retire updates in a small FIFO. Fetch has priority; updates issue on idle fetch cycles, on starvation, when the FIFO is full, or during a drain.
- Drives the PHT's enable, pc_in and branch_taken inputs and returns the PHT prediction to fetch.

Parameters:
- PC_W, 32, width of all PC fields.
- QDEPTH, 4, update FIFO entries (power of 2, at least 2).
- STARVE_LIMIT, 8, consecutive cycles fetch may win over a non-empty FIFO before one update is forced.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_valid  in  1  fetch lookup request.
- fetch_pc  in  PC_W  lookup PC.
- fetch_ready  out  1  lookup granted this cycle.
- fetch_pred  out  1  prediction for fetch_pc; valid when fetch_valid and fetch_ready are both high.
- upd_valid  in  1  retire update request.
- upd_pc  in  PC_W  PC of the resolved branch.
- upd_taken  in  1  resolved direction.
- upd_ready  out  1  FIFO can accept an update.
- drain_req  in  1  request to empty the FIFO with update priority.
- drain_done  out  1  one-cycle pulse when a drain completes.
- q_count  out  $clog2(QDEPTH+1)  FIFO occupancy.
- pht_enable  out  1  PHT update strobe.
- pht_pc  out  PC_W  PHT index PC.
- pht_branch_taken  out  1  PHT update direction.
- pht_prediction  in  1  PHT combinational prediction for pht_pc.

Behaviour:
- Reset (reset low, asynchronous):
  - FIFO empty, q_count=0, upd_ready=1.
  - starve_cnt=0, state=IDLE, drain_done=0.
  - Head/tail pointers = 0.
- FIFO:
  - upd_ready = (q_count != QDEPTH).
  - Enqueue on upd_valid && upd_ready, at the rising edge.
  - Dequeue the head when grant_upd is high.
  - When full, no enqueue occurs even if a dequeue happens the same cycle.
  - Enqueue and dequeue in the same cycle leave q_count unchanged.
  - Pointers wrap modulo QDEPTH.
  - FIFO order is preserved; entries are never merged or dropped.
- Grant (combinational):
  - grant_upd = (q_count != 0) && (state==DRAIN || !fetch_valid || q_count==QDEPTH || starve_cnt==STARVE_LIMIT).
  - fetch_ready = !grant_upd.
  - pht_enable = grant_upd.
  - pht_pc = grant_upd ? head_pc : fetch_pc.
  - pht_branch_taken = grant_upd ? head_taken : 0.
  - fetch_pred = fetch_ready ? pht_prediction : 0.
  - Lookup latency is 0 cycles. An update takes effect in the PHT at the granting edge.
- Starvation counter:
  - Increments when fetch_valid && fetch_ready && q_count!=0.
  - Clears to 0 on grant_upd or when q_count==0.
  - Saturates at STARVE_LIMIT.
- FSM:
  - IDLE to DRAIN on drain_req.
  - DRAIN to IDLE when q_count==1 and grant_upd with no same-cycle enqueue, or when q_count==0. drain_done pulses on that transition.
  - drain_req while already in DRAIN is ignored.
  - drain_req with an empty FIFO produces a drain_done pulse on the next cycle.
  - While in DRAIN, upd_ready is forced to 0 so the drain terminates.
- Reset asserted mid-drain: the FIFO is discarded, state returns to IDLE, and no drain_done pulse is issued.

Optional Feature:
- Macro: PHT_ARB_STATS_EN.
- When defined, the block adds three 32-bit wrapping outputs, each cleared by reset:
  - stat_lookups: counts fetch grants.
  - stat_updates: counts update grants.
  - stat_stalls: counts cycles with fetch_valid && !fetch_ready.
- When undefined, these ports and their counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset release, idle inputs: q_count=0, upd_ready=1, pht_enable=0, drain_done=0.
- Updates with fetch idle:
  - Stimulus: upd_valid with pc=0x0, taken=1 in cycle 1; fetch_valid=0.
  - Response: cycle 2 shows pht_enable=1, pht_pc=0x0, pht_branch_taken=1; cycle 3 shows q_count=0.
  - Apply the same PC three times; PHT row 0 must end at 2'b11.
- Starvation:
  - Stimulus: fetch_valid held at 1 with one update queued.
  - Response: exactly 8 fetch grants, then one cycle with fetch_ready=0 and pht_enable=1, then fetch grants resume.
- Full FIFO:
  - Stimulus: enqueue 4 updates while fetch_valid=1.
  - Response: upd_ready=0 at q_count=4; a forced update the next cycle; upd_ready=1 again.
  - An upd_valid presented while full is not enqueued.
- Drain:
  - Stimulus: 3 entries queued, fetch_valid=1, pulse drain_req.
  - Response: 3 consecutive update grants, upd_ready=0 throughout, drain_done pulses once, state returns to IDLE.
- Reset mid-drain: assert reset with 2 entries in DRAIN -> q_count=0 immediately, no drain_done pulse, pht_enable=0.
